// File: rtl/harris_nms.sv
// 3x3 non-maximum suppression over a raster stream of Harris scores, with two line buffers.
// Optional macro HARRIS_NMS_SCORE_OUT_EN adds an 8-bit corner_score output.
module harris_nms #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] harris_in,
  input  logic [7:0] thresh,
  output logic       en_c,
  output logic       corner_out,
`ifdef HARRIS_NMS_SCORE_OUT_EN
  output logic [7:0] corner_score,
`endif
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    thr_r;

  logic [7:0]    lb_a [IMG_W];
  logic [7:0]    lb_b [IMG_W];
  logic [7:0]    win  [3][2];

  logic          col_last;
  logic          row_last;
  logic [7:0]    in_top;
  logic [7:0]    in_mid;
  logic          out_valid;
  logic          is_corner;
  logic [7:0]    centre;
  logic          ge_all;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  // Window is the two previous columns plus the incoming one, so the centre is win[1][1].
  always_comb begin
    in_top    = lb_b[col];
    in_mid    = lb_a[col];
    centre    = win[1][1];
    ge_all    = (centre >= win[0][0]) && (centre >= win[1][0]) && (centre >= win[2][0]) &&
                (centre >= win[0][1]) && (centre >= win[2][1]) &&
                (centre >= in_top)    && (centre >= in_mid)    && (centre >= harris_in);
    out_valid = en && (state == RUN) && (row != RW'(0)) && (col != CW'(0));
    // Centre row/col 0 is border; this also hides stale lines and wrapped columns.
    if (out_valid && (row > RW'(1)) && (col > CW'(1)) && (centre > thr_r)) begin
      is_corner = ge_all;
    end else begin
      is_corner = 1'b0;
    end
  end

  // Next-state logic for the fill/run sequencing.
  always_comb begin
    state_nx = state;
    case (state)
      FILL: begin
        if (en && (row == RW'(0)) && col_last) begin
          state_nx = RUN;
        end else begin
          state_nx = FILL;
        end
      end
      RUN: begin
        if (en && row_last && col_last) begin
          state_nx = FILL;
        end else begin
          state_nx = RUN;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // Line buffers and window are data only and deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      lb_a[col] <= harris_in;
      lb_b[col] <= lb_a[col];
      win[0][0] <= win[0][1];
      win[1][0] <= win[1][1];
      win[2][0] <= win[2][1];
      win[0][1] <= in_top;
      win[1][1] <= in_mid;
      win[2][1] <= harris_in;
    end
  end

  // Counters, state, threshold capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      col        <= CW'(0);
      row        <= RW'(0);
      thr_r      <= 8'd0;
      en_c       <= 1'b0;
      corner_out <= 1'b0;
      frame_done <= 1'b0;
`ifdef HARRIS_NMS_SCORE_OUT_EN
      corner_score <= 8'd0;
`endif
    end else begin
      state      <= state_nx;
      en_c       <= out_valid;
      corner_out <= is_corner;
      frame_done <= en && row_last && col_last;
`ifdef HARRIS_NMS_SCORE_OUT_EN
      corner_score <= is_corner ? centre : 8'd0;
`endif
      if (en) begin
        if ((row == RW'(0)) && (col == CW'(0))) begin
          thr_r <= thresh;
        end
        if (col_last) begin
          col <= CW'(0);
          row <= row_last ? RW'(0) : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_harris_nms.sv
// Scoreboard bench for harris_nms at IMG_W=8, IMG_H=6 using directed frames.
module tb_harris_nms;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] harris_in;
  logic [7:0] thresh;
  logic       en_c;
  logic       corner_out;
  logic       frame_done;
`ifdef HARRIS_NMS_SCORE_OUT_EN
  logic [7:0] corner_score;
`endif

  harris_nms #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .en(en), .harris_in(harris_in), .thresh(thresh),
    .en_c(en_c), .corner_out(corner_out),
`ifdef HARRIS_NMS_SCORE_OUT_EN
    .corner_score(corner_score),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic c; logic [7:0] s; logic fd; } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int valid_seen = 0;
  int fd_seen = 0;
  int corners_seen = 0;
  logic mon_on = 1'b0;
  logic en_q = 1'b0;
  logic [7:0] img [H][W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) en_q <= en;

  // Monitor: pop one expectation per en_c; outputs must be quiet otherwise.
  always @(negedge clk) begin
    if (mon_on) begin
      if (en_c === 1'b1) begin
        exp_t e;
        valid_seen++;
        if (frame_done === 1'b1) fd_seen++;
        if (corner_out === 1'b1) corners_seen++;
        chk("en_c_after_idle", en_q, 1);
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("corner_out", corner_out, e.c);
          chk("frame_done", frame_done, e.fd);
`ifdef HARRIS_NMS_SCORE_OUT_EN
          chk("corner_score", corner_score, e.s);
`endif
        end
      end else begin
        chk("idle_corner_out", corner_out, 0);
        chk("idle_frame_done", frame_done, 0);
      end
    end
  end

  function automatic logic ref_corner(input logic [7:0] th, input int cr, input int cc);
    logic ok;
    if (cr < 1 || cc < 1 || cr > H - 2 || cc > W - 2) return 1'b0;
    ok = img[cr][cc] > th;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (img[cr][cc] < img[cr+dr][cc+dc]) ok = 1'b0;
    return ok;
  endfunction

  task automatic fill_img(input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  // Thresh only matters on pixel (0,0); afterwards it is driven to its complement.
  task automatic send_frame(input logic [7:0] th, input bit gaps, input int npix);
    int n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          while (gaps && $urandom_range(0, 99) < 30) begin
            en = 1'b0;
            harris_in = 8'($urandom_range(0, 255));
            thresh = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
          end
          en = 1'b1;
          harris_in = img[r][c];
          thresh = (r == 0 && c == 0) ? th : ~th;
          if (r >= 1 && c >= 1) begin
            exp_t e;
            e.c  = ref_corner(th, r - 1, c - 1);
            e.s  = e.c ? img[r-1][c-1] : 8'd0;
            e.fd = (r == H - 1) && (c == W - 1);
            q.push_back(e);
          end
          @(posedge clk); #1;
          n++;
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int exp_corners);
    int waitc = 0;
    while (q.size() != 0 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({name, "_drained"}, q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_valid_count"}, valid_seen, 35);
    chk({name, "_frame_done_count"}, fd_seen, 1);
    chk({name, "_corner_count"}, corners_seen, exp_corners);
    valid_seen = 0; fd_seen = 0; corners_seen = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; harris_in = 8'd0; thresh = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en_c", en_c, 0);
    chk("reset_corner_out", corner_out, 0);
    chk("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    fill_img(8'd0);
    send_frame(8'd0, 1'b0, W * H);
    finish_frame("all_zero", 0);

    fill_img(8'd10); img[3][4] = 8'd200;
    send_frame(8'd50, 1'b0, W * H);
    finish_frame("single_peak", 1);

    fill_img(8'd10); img[0][3] = 8'd200; img[2][0] = 8'd200;
    send_frame(8'd50, 1'b0, W * H);
    finish_frame("border", 0);

    fill_img(8'd10); img[2][2] = 8'd200; img[2][3] = 8'd200;
    send_frame(8'd50, 1'b0, W * H);
    finish_frame("tie_low_thresh", 2);
    send_frame(8'd200, 1'b0, W * H);
    finish_frame("tie_high_thresh", 0);

    fill_img(8'd10); img[3][4] = 8'd200;
    send_frame(8'd50, 1'b1, W * H);
    finish_frame("gaps", 1);

    send_frame(8'd50, 1'b0, 20);
    repeat (2) @(posedge clk);
    #1;
    valid_seen = 0; fd_seen = 0; corners_seen = 0;
    rst = 1'b1; en = 1'b1; harris_in = 8'd255; thresh = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    chk("midreset_en_c", en_c, 0);
    chk("midreset_frame_done", frame_done, 0);
    send_frame(8'd50, 1'b0, W * H);
    finish_frame("after_reset", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/harris_nms.md
HARRIS_NMS -- requirements
Module: harris_nms

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter IMG_W SHALL be: IMG_W, default 640, pixels per line (range 4..2048).
REQ-003 Parameter IMG_H SHALL be: IMG_H, default 480, lines per frame (range 3..2048).
REQ-004 Port clk SHALL be: clk  input  1  system clock, all logic on rising edge.
REQ-005 Port rst SHALL be: rst  input  1  synchronous active-high reset.
REQ-006 Port en SHALL be: en  input  1  harris_in valid this cycle, raster order.
REQ-007 Port harris_in SHALL be: harris_in  input  8  unsigned cornerness score from the Harris stage.
REQ-008 Port thresh SHALL be: thresh  input  8  unsigned detection threshold.
REQ-009 Port en_c SHALL be: en_c  output  1  corner_out valid.
REQ-010 Port corner_out SHALL be: corner_out  output  1  1 = window centre is a corner.
REQ-011 Port frame_done SHALL be: frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-012 The block SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters; they advance only on en=1, col wraps to 0 and increments row, and row wraps to 0 after (IMG_H-1, IMG_W-1).
REQ-013 The block SHALL keep two IMG_W x 8 line buffers plus a 3x3 window register, all shifted only on en=1; en=0 SHALL freeze all state, with no output.
REQ-014 The FSM SHALL have states FILL and RUN: reset enters FILL; FILL goes to RUN on the pixel accepted at (0, IMG_W-1); RUN goes to FILL on the pixel accepted at (IMG_H-1, IMG_W-1).
REQ-015 thresh SHALL be sampled into an internal register on the pixel accepted at (0,0) and held for the whole frame.
REQ-016 A pixel accepted at (row,col) with row>=1 and col>=1 SHALL produce exactly one output for centre (row-1,col-1), with en_c=1 on the next cycle (latency 1 clk after the accepting edge).
REQ-017 No output (en_c=0) SHALL be produced for pixels with row=0 or col=0; outputs per frame = (IMG_H-1)*(IMG_W-1).
REQ-018 corner_out SHALL be 1 iff centre > registered thresh (strict), centre >= each of the 8 neighbours (unsigned), and the centre is not on a border (centre row 0 or centre col 0).
REQ-019 Ties SHALL flag every tied maximum; a plateau of equal values above thresh yields multiple corners.
REQ-020 A window SHALL never mix pixels across a line wrap into a flagged result; border suppression (REQ-018) guarantees this.
REQ-021 frame_done SHALL pulse 1 cycle after the pixel accepted at (IMG_H-1, IMG_W-1), coincident with that pixel's en_c.
REQ-022 When en_c=0, corner_out SHALL be 0.

Reset
REQ-023 On rst=1 at a clock edge: en_c=0, corner_out=0, frame_done=0, col=0, row=0, FSM=FILL, thresh register=0.
REQ-024 Line-buffer contents SHALL NOT be cleared by reset; stale data SHALL be unobservable because FILL produces no output.
REQ-025 A reset mid-frame SHALL abandon the frame; the next accepted pixel is treated as (0,0).
REQ-026 rst SHALL override en in the same cycle.

Configuration
REQ-027 With macro HARRIS_NMS_SCORE_OUT_EN defined, an extra output corner_score (8 bits) SHALL equal the centre value when corner_out=1 and 0 otherwise, with the same timing, reset value 0.
REQ-028 Without HARRIS_NMS_SCORE_OUT_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (IMG_W=8, IMG_H=6)
REQ-029 All-zero frame, thresh=0 -> 35 en_c pulses, all corner_out=0, a single frame_done.
REQ-030 Single 200 at (3,4), others 10, thresh=50 -> exactly one corner_out=1, at the output for centre (3,4), 1 clk after pixel (4,5) is accepted.
REQ-031 Value 200 at (0,3) and at (2,0), thresh=50 -> no corner flagged (border suppression).
REQ-032 Two adjacent 200s at (2,2) and (2,3), thresh=50 -> both flagged (tie rule); with thresh=200 -> neither flagged.
REQ-033 Random en gaps, 30% idle -> the output sequence matches the gap-free run; en_c never asserts in a cycle following en=0.
REQ-034 rst pulsed after 20 pixels, then a full frame sent -> the result equals a clean frame; with SCORE_OUT_EN, corner_score=200 on the flagged output in REQ-030.
